// File: rtl/writeback_register_file.sv
// Purpose : MIPS writeback stage - selects the writeback result, commits it to the register file, counts committed writes.
// Latency : ResultW/RD1/RD2 are combinational; a write is visible in the array one CLK edge after it is presented.
// Backpressure: none - every valid writeback commits in exactly one cycle, no handshake.
//
// Ports:
//   CLK, RST         pipeline clock (rising edge), synchronous active-low reset
//   RegWriteW        writeback enable from MEM/WB
//   MemtoRegW        1: result = ReadDataW, 0: result = ALUOutW
//   ReadDataW        data-memory load data
//   ALUOutW          ALU result
//   WriteRegW        destination register (register 0 is hardwired to zero)
//   A1/A2, RD1/RD2   two asynchronous decode read ports
//   ResultW          selected writeback result, exported to the forwarding muxes
//   WbCount          committed-write counter, wraps at 2^CNT_WIDTH
//
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through on both
// read ports. Without it, reads return the pre-edge array value and the hazard
// unit must stall decode one cycle on a WB->ID dependency.
module writeback_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegW,
  input  logic [DATA_WIDTH-1:0] ReadDataW,
  input  logic [DATA_WIDTH-1:0] ALUOutW,
  input  logic [ADDR_WIDTH-1:0] WriteRegW,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [CNT_WIDTH-1:0]  WbCount
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]  wb_count_q;
  logic [CNT_WIDTH-1:0]  wb_count_d;
  logic                  commit;

  // Result mux is independent of the write enable and reset so forwarding
  // always sees the value in flight.
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

  // A committed write: out of reset, enabled, and not aimed at $zero.
  // Gating on RST here also suppresses the bypass while reset is held.
  assign commit = RST && RegWriteW && (WriteRegW != '0);

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (commit) begin
      regs_d[WriteRegW] = ResultW;
      wb_count_d        = wb_count_q + CNT_WIDTH'(1);
    end
  end

  // Reset has priority, so a write presented during reset is discarded.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  always_comb begin
    if (A1 == '0) begin
      RD1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (commit && (WriteRegW == A1)) begin
      RD1 = ResultW;
    end
`endif
    else begin
      RD1 = regs_q[A1];
    end
  end

  always_comb begin
    if (A2 == '0) begin
      RD2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (commit && (WriteRegW == A2)) begin
      RD2 = ResultW;
    end
`endif
    else begin
      RD2 = regs_q[A2];
    end
  end

  assign WbCount = wb_count_q;

endmodule
